// File: rtl/id_stage_pipe.sv
// Registered RV32I/RV64I decode stage with a one-entry output register.
// Latency 1: fields and regfile data captured on accept; read addresses are combinational.
// Backpressure: in_ready = !out_valid | out_ready; a held entry is stable until consumed.
module id_stage_pipe #(
  parameter int XLEN    = 64,
  parameter bit RV64_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            flush_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic [XLEN-1:0] base_addr_o,
  output logic [XLEN-1:0] offset_addr_o,
  output logic            mem_ren_o,
  output logic            mem_wen_o,
  output logic [1:0]      mem_size_o,
  output logic            mem_unsigned_o,
  output logic            word_op_o,
  output logic            illegal_o
);

  localparam bit RV64 = (XLEN == 64) && RV64_EN;
  localparam int SHW  = (XLEN == 64) ? 6 : 5;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;
    logic [4:0]      rd;
    logic            reg_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            word_op;
    logic            illegal;
  } dec_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [6:0] f7_shift;
  logic [63:0] imm_i64, imm_s64, imm_b64, imm_u64, imm_j64;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic       legal;
  logic       accept;
  dec_t       d;
  dec_t       q;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  // On RV64 the shamt borrows inst[25], so only the upper six funct bits qualify the shift.
  assign f7_shift = (XLEN == 64) ? {inst_i[31:26], 1'b0} : inst_i[31:25];

  assign imm_i64 = {{52{inst_i[31]}}, inst_i[31:20]};
  assign imm_s64 = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b64 = {{52{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u64 = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
  assign imm_j64 = {{44{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_i   = imm_i64[XLEN-1:0];
  assign imm_s   = imm_s64[XLEN-1:0];
  assign imm_b   = imm_b64[XLEN-1:0];
  assign imm_u   = imm_u64[XLEN-1:0];
  assign imm_j   = imm_j64[XLEN-1:0];
  assign shamt   = XLEN'(inst_i[20 +: SHW]);

  always_comb begin
    rs1_addr_o = 5'd0;
    rs2_addr_o = 5'd0;
    case (opcode)
      OPC_OP_IMM, OPC_JALR, OPC_LOAD: rs1_addr_o = inst_i[19:15];
      OPC_OP, OPC_BRANCH, OPC_STORE: begin
        rs1_addr_o = inst_i[19:15];
        rs2_addr_o = inst_i[24:20];
      end
      OPC_OP_IMM32: if (RV64) rs1_addr_o = inst_i[19:15];
      OPC_OP32: if (RV64) begin
        rs1_addr_o = inst_i[19:15];
        rs2_addr_o = inst_i[24:20];
      end
      default: ;
    endcase
  end

  always_comb begin
    d         = '0;
    legal     = 1'b1;
    d.inst    = inst_i;
    d.pc      = inst_addr_i;
    d.rd      = inst_i[11:7];
    case (opcode)
      OPC_OP_IMM: begin
        d.op1     = rs1_data_i;
        d.reg_wen = 1'b1;
        case (f3)
          3'b001: begin
            d.op2 = shamt;
            legal = (f7_shift == 7'b0);
          end
          3'b101: begin
            d.op2 = shamt;
            legal = (f7_shift == 7'b0) || (f7_shift == 7'b0100000);
          end
          default: d.op2 = imm_i;
        endcase
      end
      OPC_OP: begin
        d.op1     = rs1_data_i;
        d.reg_wen = 1'b1;
        d.op2     = (f3 == 3'b001 || f3 == 3'b101) ? XLEN'(rs2_data_i[SHW-1:0]) : rs2_data_i;
        legal     = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_OP_IMM32: begin
        d.op1     = rs1_data_i;
        d.reg_wen = 1'b1;
        d.word_op = 1'b1;
        case (f3)
          3'b000:  d.op2 = imm_i;
          3'b001: begin
            d.op2 = XLEN'(inst_i[24:20]);
            legal = (f7 == 7'b0);
          end
          3'b101: begin
            d.op2 = XLEN'(inst_i[24:20]);
            legal = (f7 == 7'b0) || (f7 == 7'b0100000);
          end
          default: legal = 1'b0;
        endcase
        if (!RV64) legal = 1'b0;
      end
      OPC_OP32: begin
        d.op1     = rs1_data_i;
        d.reg_wen = 1'b1;
        d.word_op = 1'b1;
        case (f3)
          3'b000: begin
            d.op2 = rs2_data_i;
            legal = (f7 == 7'b0) || (f7 == 7'b0100000);
          end
          3'b001: begin
            d.op2 = XLEN'(rs2_data_i[4:0]);
            legal = (f7 == 7'b0);
          end
          3'b101: begin
            d.op2 = XLEN'(rs2_data_i[4:0]);
            legal = (f7 == 7'b0) || (f7 == 7'b0100000);
          end
          default: legal = 1'b0;
        endcase
        if (!RV64) legal = 1'b0;
      end
      OPC_BRANCH: begin
        d.op1    = rs1_data_i;
        d.op2    = rs2_data_i;
        d.base   = inst_addr_i;
        d.offset = imm_b;
        legal    = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OPC_JAL: begin
        d.op1     = inst_addr_i;
        d.op2     = XLEN'(4);
        d.base    = inst_addr_i;
        d.offset  = imm_j;
        d.reg_wen = 1'b1;
      end
      OPC_JALR: begin
        d.op1     = inst_addr_i;
        d.op2     = XLEN'(4);
        d.base    = rs1_data_i;
        d.offset  = imm_i;
        d.reg_wen = 1'b1;
        legal     = (f3 == 3'b000);
      end
      OPC_LUI: begin
        d.op2     = imm_u;
        d.reg_wen = 1'b1;
      end
      OPC_AUIPC: begin
        d.op1     = inst_addr_i;
        d.op2     = imm_u;
        d.reg_wen = 1'b1;
      end
      OPC_LOAD: begin
        d.base         = rs1_data_i;
        d.offset       = imm_i;
        d.mem_ren      = 1'b1;
        d.reg_wen      = 1'b1;
        d.mem_size     = f3[1:0];
        d.mem_unsigned = f3[2];
        legal          = (f3 != 3'b111) && (RV64 || (f3 != 3'b011 && f3 != 3'b110));
      end
      OPC_STORE: begin
        d.base     = rs1_data_i;
        d.offset   = imm_s;
        d.op2      = rs2_data_i;
        d.mem_wen  = 1'b1;
        d.mem_size = f3[1:0];
        legal      = !f3[2] && (RV64 || f3 != 3'b011);
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      d         = '0;
      d.inst    = inst_i;
      d.pc      = inst_addr_i;
      d.illegal = 1'b1;
    end else if (!d.reg_wen || d.rd == 5'd0) begin
      d.rd      = 5'd0;
      d.reg_wen = 1'b0;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign inst_o         = q.inst;
  assign inst_addr_o    = q.pc;
  assign op1_o          = q.op1;
  assign op2_o          = q.op2;
  assign rd_addr_o      = q.rd;
  assign reg_wen_o      = q.reg_wen;
  assign base_addr_o    = q.base;
  assign offset_addr_o  = q.offset;
  assign mem_ren_o      = q.mem_ren;
  assign mem_wen_o      = q.mem_wen;
  assign mem_size_o     = q.mem_size;
  assign mem_unsigned_o = q.mem_unsigned;
  assign word_op_o      = q.word_op;
  assign illegal_o      = q.illegal;

endmodule
